// File: rtl/ysyx_22050854_mdu_pkg.sv
// ysyx_22050854_mdu_pkg
// Shared definitions for the iterative RV64M multiply/divide unit:
//   - MULctr operation codes as produced by the decode stage
//   - FSM state enum {IDLE, CALC, FIX, DONE}
//   - iteration counts for doubleword (64) and word (32) operations
//   - small helpers for sign extension and multiply result selection
package ysyx_22050854_mdu_pkg;

    localparam int MDU_XLEN = 64;

    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_DIV    = 4'b0100;
    localparam logic [3:0] OP_DIVU   = 4'b0101;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;
    localparam logic [3:0] OP_MULW   = 4'b1000;
    localparam logic [3:0] OP_MUL    = 4'b1001;
    localparam logic [3:0] OP_DIVW   = 4'b1100;
    localparam logic [3:0] OP_DIVUW  = 4'b1101;
    localparam logic [3:0] OP_REMW   = 4'b1110;
    localparam logic [3:0] OP_REMUW  = 4'b1111;

    localparam logic [6:0] ITER_DWORD = 7'd64;
    localparam logic [6:0] ITER_WORD  = 7'd32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Pick the architectural result out of a (sign-corrected) 128-bit product.
    function automatic logic [63:0] mul_select(input logic [3:0] op, input logic [127:0] p);
        logic [63:0] r;
        case (op)
            OP_MULH, OP_MULHSU, OP_MULHU: r = p[127:64];
            OP_MULW:                      r = sext32(p[31:0]);
            default:                      r = p[63:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22050854_div_iter.sv
// ysyx_22050854_div_iter
// One combinational restoring-division step.
//   rem          in   current partial remainder (always < divisor)
//   dividend_bit in   next dividend bit, MSB first
//   divisor      in   divisor magnitude
//   rem_next     out  partial remainder after this step
//   q_bit        out  quotient bit produced by this step
module ysyx_22050854_div_iter
    import ysyx_22050854_mdu_pkg::*;
(
    input  logic [MDU_XLEN-1:0] rem,
    input  logic                dividend_bit,
    input  logic [MDU_XLEN-1:0] divisor,
    output logic [MDU_XLEN-1:0] rem_next,
    output logic                q_bit
);

    logic [MDU_XLEN:0] shifted;
    logic [MDU_XLEN:0] diff;

    // One extra bit: the shifted remainder can reach 2*divisor-1, which
    // overflows 64 bits when the divisor is large.
    assign shifted  = {rem, dividend_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[MDU_XLEN];
    assign rem_next = q_bit ? diff[MDU_XLEN-1:0] : shifted[MDU_XLEN-1:0];

endmodule

// File: rtl/ysyx_22050854_mdu.sv
// ysyx_22050854_mdu
// Iterative RV64M multiply/divide unit (1 bit per cycle shift-add multiply,
// restoring divide). Special cases (divide by zero, signed overflow, unused
// codes) finish through IDLE->FIX->DONE.
// Ports:
//   clk, rst_n (async active-low), flush (sync cancel)
//   in_valid/in_ready, mul_ctr[3:0], src1/src2 : request side
//   out_valid/out_ready, result                : response side
//   busy                                       : high whenever not IDLE
// Build option: define YSYX_22050854_MDU_FAST_MUL_EN to compute every multiply
// with a single-cycle product on the special path.
module ysyx_22050854_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      mul_ctr,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    import ysyx_22050854_mdu_pkg::*;

    state_t state_reg, state_next;

    // Request decode (combinational, from the live inputs)
    logic            op_div, op_mul, op_inval, op_word, sgn_a, sgn_b;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_val, fast_val;
    logic            neg_a, neg_b, div_zero, div_ovf, special, accept;

    // Latched operation and datapath
    logic [6:0]        cnt_reg;
    logic [3:0]        op_reg;
    logic              word_reg, div_reg, special_reg, neg_q_reg, neg_r_reg;
    logic [XLEN-1:0]   spec_val_reg, result_reg;
    logic [2*XLEN-1:0] acc_reg, mcand_reg;
    logic [XLEN-1:0]   mplier_reg, rem_reg, dvd_reg, quot_reg, divisor_reg;
    logic [XLEN-1:0]   rem_next, fix_val, q_fix, r_fix, div_sel;
    logic [2*XLEN-1:0] prod_fix;
    logic              q_bit;

`ifdef YSYX_22050854_MDU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    logic [2*XLEN-1:0] fast_prod, fast_signed;
    assign fast_prod   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
    assign fast_signed = (neg_a ^ neg_b) ? -fast_prod : fast_prod;
    assign fast_val    = mul_select(mul_ctr, fast_signed);
`else
    localparam logic FAST_MUL = 1'b0;
    assign fast_val = '0;
`endif

    always_comb begin
        op_div   = mul_ctr[2];
        op_mul   = mul_ctr inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW, OP_MUL};
        op_inval = !op_div && !op_mul;
        op_word  = mul_ctr[3] && (mul_ctr[2] || mul_ctr == OP_MULW);
        sgn_a    = mul_ctr inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM, OP_DIVW, OP_REMW};
        sgn_b    = mul_ctr inside {OP_MULH, OP_DIV, OP_REM, OP_DIVW, OP_REMW};

        a_ext = src1;
        b_ext = src2;
        if (op_word) begin
            a_ext = sgn_a ? sext32(src1[31:0]) : {32'b0, src1[31:0]};
            b_ext = sgn_b ? sext32(src2[31:0]) : {32'b0, src2[31:0]};
        end
        neg_a = sgn_a & a_ext[XLEN-1];
        neg_b = sgn_b & b_ext[XLEN-1];
        a_mag = neg_a ? -a_ext : a_ext;
        b_mag = neg_b ? -b_ext : b_ext;

        div_zero = op_div && (b_ext == '0);
        // Only signed divides (which are exactly the divides with sgn_b) can overflow.
        div_ovf  = op_div && sgn_b && (b_ext == '1) &&
                   (a_ext == (op_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special  = op_inval || div_zero || div_ovf || (FAST_MUL && op_mul);

        spec_val = '0;
        if (div_zero)
            spec_val = mul_ctr[1] ? (op_word ? sext32(src1[31:0]) : src1) : '1;
        else if (div_ovf)
            spec_val = mul_ctr[1] ? '0 : a_ext;
        else if (op_mul)
            spec_val = fast_val;
    end

    assign accept = (state_reg == IDLE) && in_valid && !flush;

    // Next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = special ? FIX : CALC;
            CALC: if (cnt_reg == 7'd1) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    ysyx_22050854_div_iter u_div_iter (
        .rem          (rem_reg),
        .dividend_bit (dvd_reg[XLEN-1]),
        .divisor      (divisor_reg),
        .rem_next     (rem_next),
        .q_bit        (q_bit)
    );

    // Sign correction and result selection for the FIX state
    always_comb begin
        prod_fix = neg_q_reg ? -acc_reg : acc_reg;
        q_fix    = neg_q_reg ? -quot_reg : quot_reg;
        r_fix    = neg_r_reg ? -rem_reg : rem_reg;
        div_sel  = op_reg[1] ? r_fix : q_fix;
        if (special_reg)
            fix_val = spec_val_reg;
        else if (div_reg)
            fix_val = word_reg ? sext32(div_sel[31:0]) : div_sel;
        else
            fix_val = mul_select(op_reg, prod_fix);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            op_reg       <= '0;
            word_reg     <= 1'b0;
            div_reg      <= 1'b0;
            special_reg  <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            spec_val_reg <= '0;
            acc_reg      <= '0;
            mcand_reg    <= '0;
            mplier_reg   <= '0;
            rem_reg      <= '0;
            dvd_reg      <= '0;
            quot_reg     <= '0;
            divisor_reg  <= '0;
            result_reg   <= '0;
        end else if (accept) begin
            cnt_reg      <= op_word ? ITER_WORD : ITER_DWORD;
            op_reg       <= mul_ctr;
            word_reg     <= op_word;
            div_reg      <= op_div;
            special_reg  <= special;
            neg_q_reg    <= neg_a ^ neg_b;
            neg_r_reg    <= neg_a;
            spec_val_reg <= spec_val;
            acc_reg      <= '0;
            mcand_reg    <= {{XLEN{1'b0}}, a_mag};
            mplier_reg   <= b_mag;
            rem_reg      <= '0;
            // Word dividends are pre-aligned so their MSB is consumed first.
            dvd_reg      <= op_word ? {a_mag[31:0], 32'b0} : a_mag;
            quot_reg     <= '0;
            divisor_reg  <= b_mag;
        end else if (state_reg == CALC) begin
            cnt_reg <= cnt_reg - 7'd1;
            if (div_reg) begin
                rem_reg  <= rem_next;
                quot_reg <= {quot_reg[XLEN-2:0], q_bit};
                dvd_reg  <= {dvd_reg[XLEN-2:0], 1'b0};
            end else begin
                if (mplier_reg[0]) acc_reg <= acc_reg + mcand_reg;
                mcand_reg  <= {mcand_reg[2*XLEN-2:0], 1'b0};
                mplier_reg <= {1'b0, mplier_reg[XLEN-1:1]};
            end
        end else if (state_reg == FIX && !flush) begin
            result_reg <= fix_val;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;

endmodule

// File: tb/tb_ysyx_22050854_mdu.sv
module tb_ysyx_22050854_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  mul_ctr = 4'd0;
    logic [63:0] src1 = 64'd0;
    logic [63:0] src2 = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    logic was_valid = 1'b0;

    ysyx_22050854_mdu #(.XLEN(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mul_ctr   (mul_ctr),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    function automatic logic [63:0] sx(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Behavioural reference: plain arithmetic on the RISC-V M-extension rules.
    function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        logic signed [63:0]  sa, sb;
        logic signed [31:0]  wa, wb;
        logic [31:0]         ua, ub, w;
        sa = a; sb = b; wa = a[31:0]; wb = b[31:0]; ua = a[31:0]; ub = b[31:0];
        case (op)
            4'b0001: begin pa = sa; pb = sb; p = pa * pb; return p[127:64]; end
            4'b0010: begin pa = sa; pb = $signed({64'd0, b}); p = pa * pb; return p[127:64]; end
            4'b0011: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
            4'b0100: begin
                if (b == 64'd0) return ONES;
                if (a == MIN64 && b == ONES) return a;
                return sa / sb;
            end
            4'b0101: return (b == 64'd0) ? ONES : a / b;
            4'b0110: begin
                if (b == 64'd0) return a;
                if (a == MIN64 && b == ONES) return 64'd0;
                return sa % sb;
            end
            4'b0111: return (b == 64'd0) ? a : a % b;
            4'b1000: begin w = ua * ub; return sx(w); end
            4'b1001: return a * b;
            4'b1100: begin
                if (ub == 32'd0) return ONES;
                if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return sx(ua);
                w = wa / wb; return sx(w);
            end
            4'b1101: begin
                if (ub == 32'd0) return ONES;
                w = ua / ub; return sx(w);
            end
            4'b1110: begin
                if (ub == 32'd0) return sx(ua);
                if (ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) return 64'd0;
                w = wa % wb; return sx(w);
            end
            4'b1111: begin
                if (ub == 32'd0) return sx(ua);
                w = ua % ub; return sx(w);
            end
            default: return 64'd0;
        endcase
    endfunction

    // Cycles from acceptance to the first out_valid cycle.
    function automatic int latency(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic word, sgn;
        word = op[3];
        sgn  = !op[0];
        if (op == 4'b0000 || op == 4'b1010 || op == 4'b1011) return 2;
        if (op[2]) begin
            if (word ? (b[31:0] == 32'd0) : (b == 64'd0)) return 2;
            if (sgn && (word ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                             : (a == MIN64 && b == ONES))) return 2;
            return word ? 34 : 66;
        end
`ifdef YSYX_22050854_MDU_FAST_MUL_EN
        return 2;
`else
        return (op == 4'b1000) ? 34 : 66;
`endif
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return 64'd1;
            2: return ONES;
            3: return MIN64;
            4: return 64'h0000_0000_8000_0000;
            5: return 64'hFFFF_FFFF_8000_0000;
            6: return 64'($urandom_range(0, 20));
            7: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: pops the scoreboard when out_valid rises, checks the value and
    // the cycle it appeared, then checks the value stays put while held.
    always @(negedge clk) begin
        if (!rst_n) begin
            was_valid = 1'b0;
        end else if (out_valid) begin
            checks++;
            if (in_ready) begin
                fails++;
                $display("FAIL in_ready_while_valid: got %0b required 0", in_ready);
            end
            if (!was_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out_valid: result %h with empty scoreboard", result);
                end else begin
                    cur = exp_q.pop_front();
                    $display("result op=%b got=%h exp=%h cycle=%0d exp_cycle=%0d", cur.op, result, cur.res, cyc, cur.cyc);
                    if (result !== cur.res) begin
                        fails++;
                        $display("FAIL result op=%b: got %h required %h", cur.op, result, cur.res);
                    end
                    checks++;
                    if (cyc != cur.cyc) begin
                        fails++;
                        $display("FAIL latency op=%b: got cycle %0d required %0d", cur.op, cyc, cur.cyc);
                    end
                end
            end else begin
                checks++;
                if (result !== cur.res) begin
                    fails++;
                    $display("FAIL result_stable op=%b: got %h required %h", cur.op, result, cur.res);
                end
            end
            was_valid = 1'b1;
        end else begin
            was_valid = 1'b0;
        end
    end

    task automatic start(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, output int acc);
        int t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!in_ready) begin
            fails++;
            $display("FAIL in_ready_timeout: got %0b required 1", in_ready);
        end
        mul_ctr  = op;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        acc      = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready || !busy) begin
            fails++;
            $display("FAIL busy_after_accept: in_ready=%0b busy=%0b required 0/1", in_ready, busy);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b, input int hold);
        int   acc;
        int   t;
        exp_t e;
        start(op, a, b, acc);
        e.op  = op;
        e.res = ref_model(op, a, b);
        e.cyc = acc + latency(op, a, b);
        exp_q.push_back(e);
        $display("txn op=%b a=%h b=%h exp=%h hold=%0d", op, a, b, e.res, hold);
        t = 0;
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            checks++;
            fails++;
            $display("FAIL out_valid_timeout op=%b: got 0 required 1", op);
            exp_q.delete();
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (!in_ready || out_valid) begin
            fails++;
            $display("FAIL ready_after_handshake: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b busy=%0b required 1/0/0", name, in_ready, out_valid, busy);
        end
    endtask

    initial begin
        int acc;
        logic [3:0] op;

        // Reset values
        #1;
        check_idle("reset_state");
        checks++;
        if (result !== 64'd0) begin
            fails++;
            $display("FAIL reset_result: got %h required 0", result);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        issue(4'b0001, ONES, 64'd3, 0);
        issue(4'b1001, ONES, 64'd3, 1);
        issue(4'b0100, 64'd7, 64'd0, 0);
        issue(4'b0110, 64'd7, 64'd0, 2);
        issue(4'b0100, MIN64, ONES, 0);
        issue(4'b0110, MIN64, ONES, 0);
        issue(4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd2, 0);
        issue(4'b1110, 64'h0000_0000_FFFF_FFF9, 64'd2, 5);   // held result for 5 cycles
        issue(4'b0000, ONES, ONES, 0);
        issue(4'b1111, 64'h1234_5678_8765_4321, 64'hFFFF_FFFF_0000_0000, 0);

        // Flush in cycle 10 of a divu: no result, idle next cycle
        start(4'b0101, 64'd1000, 64'd3, acc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_idle("flush_to_idle");
        repeat (70) @(negedge clk);
        issue(4'b0011, ONES, ONES, 0);

        // A request under flush is not accepted
        mul_ctr  = 4'b1001;
        src1     = 64'd5;
        src2     = 64'd6;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check_idle("no_accept_under_flush");

        // Reset in the middle of an operation
        start(4'b0100, 64'd12345, 64'd17, acc);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle("midop_reset");
        checks++;
        if (result !== 64'd0) begin
            fails++;
            $display("FAIL midop_reset_result: got %h required 0", result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (70) @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, pick(), pick(), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
